// File: rtl/riscv_main_decoder.sv
// Main control decoder for the RV32I single-cycle core: opcode -> datapath controls.
// Decode is combinational; all outputs are registered, with an asynchronous active-high reset.
module riscv_main_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  output logic [1:0] ResultSrc,
  output logic       MemWrite,
  output logic       Branch,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUop,
  output logic       Illegal
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpIAlu  = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  logic [1:0] resultSrcNext;
  logic       memWriteNext;
  logic       branchNext;
  logic       aluSrcNext;
  logic       regWriteNext;
  logic       jumpNext;
  logic [1:0] immSrcNext;
  logic [1:0] aluOpNext;
  logic       illegalNext;

  // An X/Z opcode matches no item, so it falls into the all-zero illegal row.
  always_comb begin
    resultSrcNext = 2'b00;
    memWriteNext  = 1'b0;
    branchNext    = 1'b0;
    aluSrcNext    = 1'b0;
    regWriteNext  = 1'b0;
    jumpNext      = 1'b0;
    immSrcNext    = 2'b00;
    aluOpNext     = 2'b00;
    illegalNext   = 1'b0;
    case (op)
      OpLoad: begin
        regWriteNext  = 1'b1;
        aluSrcNext    = 1'b1;
        resultSrcNext = 2'b01;
      end
      OpStore: begin
        immSrcNext    = 2'b01;
        aluSrcNext    = 1'b1;
        memWriteNext  = 1'b1;
      end
      OpRType: begin
        regWriteNext  = 1'b1;
        aluOpNext     = 2'b10;
      end
      OpBeq: begin
        immSrcNext    = 2'b10;
        branchNext    = 1'b1;
        aluOpNext     = 2'b01;
      end
      OpIAlu: begin
        regWriteNext  = 1'b1;
        aluSrcNext    = 1'b1;
        aluOpNext     = 2'b10;
      end
      OpJal: begin
        regWriteNext  = 1'b1;
        immSrcNext    = 2'b11;
        resultSrcNext = 2'b10;
        jumpNext      = 1'b1;
      end
      default: illegalNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ResultSrc <= 2'b00;
      MemWrite  <= 1'b0;
      Branch    <= 1'b0;
      ALUSrc    <= 1'b0;
      RegWrite  <= 1'b0;
      Jump      <= 1'b0;
      ImmSrc    <= 2'b00;
      ALUop     <= 2'b00;
      Illegal   <= 1'b0;
    end else begin
      ResultSrc <= resultSrcNext;
      MemWrite  <= memWriteNext;
      Branch    <= branchNext;
      ALUSrc    <= aluSrcNext;
      RegWrite  <= regWriteNext;
      Jump      <= jumpNext;
      ImmSrc    <= immSrcNext;
      ALUop     <= aluOpNext;
      Illegal   <= illegalNext;
    end
  end

endmodule

// File: tb/tb_riscv_main_decoder.sv
// Bench for riscv_main_decoder: rule-based instruction-class model checked every cycle,
// plus hand-computed literal expectations for each opcode, hold and async-reset behaviour.
module tb_riscv_main_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Jump;
  logic [1:0] ImmSrc;
  logic [1:0] ALUop;
  logic       Illegal;

  int compared = 0;
  int mismatched = 0;
  bit checking = 0;

  riscv_main_decoder dut (
    .clk(clk), .rst(rst), .op(op),
    .ResultSrc(ResultSrc), .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .Jump(Jump), .ImmSrc(ImmSrc), .ALUop(ALUop), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUop, Jump, Illegal}
  logic [11:0] dutVec;
  assign dutVec = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUop, Jump, Illegal};

  // Model: derive controls from what each instruction class does, not from a decode table.
  function automatic logic [11:0] model(input logic [6:0] o);
    bit isLoad, isStore, isR, isBeq, isIAlu, isJal, legal;
    logic       regWr, aluSrc, memWr, br, jmp;
    logic [1:0] imm, res, aop;
    if ($isunknown(o)) return 12'b0000_0000_0001;
    isLoad  = (o == 7'd3);
    isStore = (o == 7'd35);
    isR     = (o == 7'd51);
    isBeq   = (o == 7'd99);
    isIAlu  = (o == 7'd19);
    isJal   = (o == 7'd111);
    legal   = isLoad | isStore | isR | isBeq | isIAlu | isJal;
    if (!legal) return 12'b0000_0000_0001;
    regWr  = isLoad | isR | isIAlu | isJal;
    aluSrc = isLoad | isStore | isIAlu;
    memWr  = isStore;
    br     = isBeq;
    jmp    = isJal;
    imm    = isStore ? 2'd1 : isBeq ? 2'd2 : isJal ? 2'd3 : 2'd0;
    res    = isLoad ? 2'd1 : isJal ? 2'd2 : 2'd0;
    aop    = (isR | isIAlu) ? 2'd2 : isBeq ? 2'd1 : 2'd0;
    return {regWr, imm, aluSrc, memWr, res, br, aop, jmp, 1'b0};
  endfunction

  logic [11:0] expVec;
  always @(posedge clk or posedge rst) begin
    if (rst) expVec <= '0;
    else     expVec <= model(op);
  end

  always @(negedge clk) begin
    if (checking) begin
      compared++;
      if (dutVec !== (rst ? 12'b0 : expVec)) begin
        mismatched++;
        $display("FAIL cycleModel op=%b got=%b want=%b", op, dutVec, rst ? 12'b0 : expVec);
      end
      compared++;
      if ((32'(MemWrite) + 32'(Branch) + 32'(Jump)) > 1) begin
        mismatched++;
        $display("FAIL exclusive got MemWrite=%b Branch=%b Jump=%b want at most one set",
                 MemWrite, Branch, Jump);
      end
    end
  end

  task automatic checkLit(input string name, input logic [11:0] want);
    compared++;
    if (dutVec !== want) begin
      mismatched++;
      $display("FAIL %s got=%b want=%b", name, dutVec, want);
    end
  endtask

  // Called just after a rising edge; sets op away from the edge, returns 1 unit after the next one.
  task automatic step(input logic [6:0] v);
    op = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    op  = 7'b0110011;
    #1 rst = 1'b1;
    #1;
    checkLit("resetAsyncNoClock", 12'b0);
    checking = 1;
    @(posedge clk); #1;
    checkLit("resetHeld", 12'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkLit("firstEdgeRType", 12'b1_00_0_0_00_0_10_0_0);

    step(7'b0010011); checkLit("iAlu",  12'b1_00_1_0_00_0_10_0_0);
    step(7'b0000011); checkLit("lw",    12'b1_00_1_0_01_0_00_0_0);
    step(7'b0100011); checkLit("sw",    12'b0_01_1_1_00_0_00_0_0);
    step(7'b1100011); checkLit("beq",   12'b0_10_0_0_00_1_01_0_0);
    step(7'b1101111); checkLit("jal",   12'b1_11_0_0_10_0_00_1_0);
    step(7'b1111111); checkLit("illegalAllOnes", 12'b0_00_0_0_00_0_00_0_1);
    step(7'b0000000); checkLit("illegalZero",    12'b0_00_0_0_00_0_00_0_1);
    step(7'b0110111); checkLit("illegalLui",     12'b0_00_0_0_00_0_00_0_1);
    step(7'bxxxxxxx); checkLit("unknownOp",      12'b0_00_0_0_00_0_00_0_1);

    // Outputs hold when op changes between edges.
    step(7'b0100011);
    op = 7'b1101111;
    #3;
    checkLit("holdBetweenEdges", 12'b0_01_1_1_00_0_00_0_0);
    @(posedge clk); #1;
    checkLit("holdThenUpdate", 12'b1_11_0_0_10_0_00_1_0);

    // Mid-cycle reset drops outputs without waiting for an edge and discards the pending decode.
    op = 7'b0000011;
    #1 rst = 1'b1;
    #1;
    checkLit("midCycleReset", 12'b0);
    @(posedge clk); #1;
    checkLit("resetDropsPending", 12'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkLit("afterResetLw", 12'b1_00_1_0_01_0_00_0_0);

    // Sweep every opcode; the per-cycle model compare covers each one.
    for (int i = 0; i < 128; i++) step(7'(i));
    step(7'b0110011);
    checkLit("sweepEndRType", 12'b1_00_0_0_00_0_10_0_0);

    @(negedge clk);
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
